// File: rtl/delay_line_engine.sv
// rtl/delay_line_engine.sv - multi-channel fractional delay engine over one shared sample RAM
// Channels are bump-allocated regions; each request writes one sample, reads two taps, interpolates and fades in.
module delay_line_engine #(
    parameter int DATA_WIDTH = 16,
    parameter int N_CHANNELS = 8,
    parameter int MEM_DEPTH  = 4096,
    parameter int FRAC_BITS  = 8,
    parameter int GAIN_STEP  = 64,
    localparam int AW = $clog2(MEM_DEPTH),
    localparam int HW = $clog2(N_CHANNELS)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    alloc_req,
    input  logic [AW-1:0]           alloc_size,
    input  logic [AW+FRAC_BITS-1:0] alloc_delay,
    output logic                    alloc_ack,
    output logic                    alloc_err,
    output logic [HW-1:0]           alloc_handle,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [HW-1:0]           req_handle,
    input  logic [DATA_WIDTH-1:0]   req_sample,
    input  logic [DATA_WIDTH-1:0]   req_delay_inc,
    output logic                    req_err,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic [HW-1:0]           resp_handle
);
    localparam int DW  = DATA_WIDTH;
    localparam int DLW = AW + FRAC_BITS;
    localparam int CW  = HW + 1;
    localparam int GW  = 15;
    localparam int SW  = ((DLW > DW) ? DLW : DW) + 2;
    localparam logic [CW-1:0] N_C    = CW'(N_CHANNELS);
    localparam logic [AW+1:0] MEM_C  = (AW+2)'(MEM_DEPTH);
    localparam logic [GW:0]   G_STEP = (GW+1)'(GAIN_STEP);
    localparam logic [GW:0]   G_ONE  = (GW+1)'(16384);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ_A, S_READ_B, S_INTERP, S_OUT} state_t;
    state_t state_q, state_d;

    logic [DW-1:0]  mem [MEM_DEPTH];
    logic [DW-1:0]  rd_data_q;

    logic [AW-1:0]  ch_base_q    [N_CHANNELS];
    logic [AW-1:0]  ch_size_q    [N_CHANNELS];
    logic [AW-1:0]  ch_pos_q     [N_CHANNELS];
    logic [DLW-1:0] ch_delay_q   [N_CHANNELS];
    logic [GW-1:0]  ch_gain_q    [N_CHANNELS];
    logic           ch_wrapped_q [N_CHANNELS];

    logic [CW-1:0]  count_q;
    logic [AW:0]    alloc_base_q;
    logic [HW-1:0]  op_handle_q, alloc_handle_q, resp_handle_q;
    logic [DW-1:0]  op_sample_q, op_inc_q, tap_a_q, y_q, resp_data_q;
    logic           alloc_ack_q, alloc_err_q, req_err_q, resp_valid_q;

    logic                 accept, req_ok, alloc_ok, wrap_now;
    logic [AW-1:0]        cur_base, cur_size, cur_pos, tap_k, tap_off, ram_addr, pos_d;
    logic [DLW-1:0]       cur_delay, delay_d, dmax_cur, alloc_dmax, alloc_delay_c;
    logic [GW-1:0]        cur_gain, gain_d;
    logic [GW:0]          gain_sum;
    logic                 cur_wrapped;
    logic signed [DW:0]   diff;
    logic signed [DW+FRAC_BITS+1:0] prod;
    logic signed [DW+GW:0] gprod;
    logic signed [SW-1:0] dsum;
    logic [DW-1:0]        y_d, resp_data_d;

    always_comb begin
        cur_base    = ch_base_q[op_handle_q];
        cur_size    = ch_size_q[op_handle_q];
        cur_pos     = ch_pos_q[op_handle_q];
        cur_delay   = ch_delay_q[op_handle_q];
        cur_gain    = ch_gain_q[op_handle_q];
        cur_wrapped = ch_wrapped_q[op_handle_q];

        // Tap B sits one sample further back than tap A; offsets wrap inside the channel region.
        tap_k    = cur_delay[DLW-1:FRAC_BITS] + {{(AW-1){1'b0}}, state_q == S_READ_B};
        tap_off  = cur_pos - tap_k + ((cur_pos < tap_k) ? cur_size : '0);
        ram_addr = cur_base + ((state_q == S_WRITE) ? cur_pos : tap_off);

        diff  = $signed({rd_data_q[DW-1], rd_data_q}) - $signed({tap_a_q[DW-1], tap_a_q});
        prod  = diff * $signed({1'b0, cur_delay[FRAC_BITS-1:0]});
        y_d   = tap_a_q + DW'(prod >>> FRAC_BITS);
        gprod = $signed(y_q) * $signed({1'b0, cur_gain});
        resp_data_d = DW'(gprod >>> 14);

        dmax_cur = {cur_size - AW'(1), {FRAC_BITS{1'b0}}} - DLW'(1);
        dsum     = $signed({{(SW-DLW){1'b0}}, cur_delay}) + $signed({{(SW-DW){op_inc_q[DW-1]}}, op_inc_q});
        if (dsum[SW-1])
            delay_d = '0;
        else if (dsum > $signed({{(SW-DLW){1'b0}}, dmax_cur}))
            delay_d = dmax_cur;
        else
            delay_d = dsum[DLW-1:0];

        wrap_now = (cur_pos == cur_size - AW'(1));
        pos_d    = wrap_now ? '0 : cur_pos + AW'(1);
        gain_sum = {1'b0, cur_gain} + G_STEP;
        gain_d   = !cur_wrapped ? cur_gain : ((gain_sum > G_ONE) ? G_ONE[GW-1:0] : gain_sum[GW-1:0]);

        alloc_dmax    = {alloc_size - AW'(1), {FRAC_BITS{1'b0}}} - DLW'(1);
        alloc_delay_c = (alloc_delay > alloc_dmax) ? alloc_dmax : alloc_delay;
        alloc_ok      = alloc_req && (count_q < N_C) && (alloc_size >= AW'(2)) &&
                        (({1'b0, alloc_base_q} + {2'b00, alloc_size}) <= MEM_C);
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        req_ok  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    req_ok = ({1'b0, req_handle} < count_q);
                    if (req_ok) state_d = S_WRITE;
                end
            end
            S_WRITE:  state_d = S_READ_A;
            S_READ_A: state_d = S_READ_B;
            S_READ_B: state_d = S_INTERP;
            S_INTERP: state_d = S_OUT;
            S_OUT:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (enable && !reset) begin
            if (state_q == S_WRITE) mem[ram_addr] <= op_sample_q;
            rd_data_q <= mem[ram_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            count_q        <= '0;
            alloc_base_q   <= '0;
            alloc_ack_q    <= 1'b0;
            alloc_err_q    <= 1'b0;
            alloc_handle_q <= '0;
            req_err_q      <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_handle_q  <= '0;
            op_handle_q    <= '0;
            op_sample_q    <= '0;
            op_inc_q       <= '0;
            tap_a_q        <= '0;
            y_q            <= '0;
        end else if (enable) begin
            state_q      <= state_d;
            alloc_ack_q  <= alloc_ok;
            alloc_err_q  <= alloc_req & ~alloc_ok;
            req_err_q    <= accept & ~req_ok;
            resp_valid_q <= (state_q == S_OUT);
            if (alloc_ok) begin
                alloc_handle_q <= count_q[HW-1:0];
                count_q        <= count_q + CW'(1);
                alloc_base_q   <= alloc_base_q + {1'b0, alloc_size};
            end
            if (accept && req_ok) begin
                op_handle_q <= req_handle;
                op_sample_q <= req_sample;
                op_inc_q    <= req_delay_inc;
            end
            if (state_q == S_READ_B) tap_a_q <= rd_data_q;
            if (state_q == S_INTERP) y_q <= y_d;
            if (state_q == S_OUT) begin
                resp_data_q   <= resp_data_d;
                resp_handle_q <= op_handle_q;
            end
        end
    end

    // A new channel index is always >= count, so it never collides with the in-flight channel's commit.
    always_ff @(posedge clk) begin
        if (!reset && enable) begin
            if (alloc_ok) begin
                ch_base_q[count_q[HW-1:0]]    <= alloc_base_q[AW-1:0];
                ch_size_q[count_q[HW-1:0]]    <= alloc_size;
                ch_pos_q[count_q[HW-1:0]]     <= '0;
                ch_delay_q[count_q[HW-1:0]]   <= alloc_delay_c;
                ch_gain_q[count_q[HW-1:0]]    <= '0;
                ch_wrapped_q[count_q[HW-1:0]] <= 1'b0;
            end
            if (state_q == S_OUT) begin
                ch_delay_q[op_handle_q]   <= delay_d;
                ch_pos_q[op_handle_q]     <= pos_d;
                ch_gain_q[op_handle_q]    <= gain_d;
                ch_wrapped_q[op_handle_q] <= cur_wrapped | wrap_now;
            end
        end
    end

    assign alloc_ack    = alloc_ack_q & enable;
    assign alloc_err    = alloc_err_q & enable;
    assign req_err      = req_err_q & enable;
    assign resp_valid   = resp_valid_q & enable;
    assign alloc_handle = alloc_handle_q;
    assign resp_data    = resp_data_q;
    assign resp_handle  = resp_handle_q;
    assign req_ready    = (state_q == S_IDLE) & enable;
endmodule

// File: tb/tb_delay_line_engine.sv
// tb/tb_delay_line_engine.sv - directed self-checking bench for delay_line_engine
module tb_delay_line_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, enable;

    logic        a_alloc_req, a_alloc_ack, a_alloc_err;
    logic [11:0] a_alloc_size;
    logic [19:0] a_alloc_delay;
    logic [2:0]  a_alloc_handle, a_req_handle, a_resp_handle;
    logic        a_req_valid, a_req_ready, a_req_err, a_resp_valid;
    logic [15:0] a_req_sample, a_req_delay_inc, a_resp_data;

    logic        b_alloc_req, b_alloc_ack, b_alloc_err;
    logic [3:0]  b_alloc_size;
    logic [11:0] b_alloc_delay;
    logic [0:0]  b_alloc_handle, b_req_handle, b_resp_handle;
    logic        b_req_valid, b_req_ready, b_req_err, b_resp_valid;
    logic [15:0] b_req_sample, b_req_delay_inc, b_resp_data;

    int vec_cnt = 0;
    int err_cnt = 0;

    delay_line_engine #(.GAIN_STEP(16384)) u_dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .alloc_req(a_alloc_req), .alloc_size(a_alloc_size), .alloc_delay(a_alloc_delay),
        .alloc_ack(a_alloc_ack), .alloc_err(a_alloc_err), .alloc_handle(a_alloc_handle),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_handle(a_req_handle),
        .req_sample(a_req_sample), .req_delay_inc(a_req_delay_inc), .req_err(a_req_err),
        .resp_valid(a_resp_valid), .resp_data(a_resp_data), .resp_handle(a_resp_handle)
    );

    delay_line_engine #(.N_CHANNELS(2), .MEM_DEPTH(16), .GAIN_STEP(64)) u_dut_b (
        .clk(clk), .reset(reset), .enable(enable),
        .alloc_req(b_alloc_req), .alloc_size(b_alloc_size), .alloc_delay(b_alloc_delay),
        .alloc_ack(b_alloc_ack), .alloc_err(b_alloc_err), .alloc_handle(b_alloc_handle),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_handle(b_req_handle),
        .req_sample(b_req_sample), .req_delay_inc(b_req_delay_inc), .req_err(b_req_err),
        .resp_valid(b_resp_valid), .resp_data(b_resp_data), .resp_handle(b_resp_handle)
    );

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b1;
        a_alloc_req = 1'b0;
        a_req_valid = 1'b0;
        b_alloc_req = 1'b0;
        b_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic a_alloc(input logic [11:0] size, input logic [19:0] dly,
                           output logic ack, output logic err, output logic [2:0] h);
        a_alloc_size = size;
        a_alloc_delay = dly;
        a_alloc_req = 1'b1;
        @(posedge clk); #1;
        ack = a_alloc_ack;
        err = a_alloc_err;
        h = a_alloc_handle;
        a_alloc_req = 1'b0;
    endtask

    task automatic b_alloc(input logic [3:0] size, input logic [11:0] dly,
                           output logic ack, output logic err, output logic [0:0] h);
        b_alloc_size = size;
        b_alloc_delay = dly;
        b_alloc_req = 1'b1;
        @(posedge clk); #1;
        ack = b_alloc_ack;
        err = b_alloc_err;
        h = b_alloc_handle;
        b_alloc_req = 1'b0;
    endtask

    task automatic a_req(input logic [2:0] h, input logic [15:0] s, input logic [15:0] inc,
                         output logic got, output logic err, output logic [15:0] d);
        int n = 0;
        while (!a_req_ready && n < 20) begin @(posedge clk); #1; n++; end
        a_req_handle = h;
        a_req_sample = s;
        a_req_delay_inc = inc;
        a_req_valid = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        err = a_req_err;
        got = 1'b0;
        d = '0;
        for (int k = 0; k < 10 && !err && !got; k++) begin
            @(posedge clk); #1;
            if (a_resp_valid) begin got = 1'b1; d = a_resp_data; end
        end
    endtask

    task automatic b_req(input logic [0:0] h, input logic [15:0] s, input logic [15:0] inc,
                         output logic got, output logic err, output logic [15:0] d);
        int n = 0;
        while (!b_req_ready && n < 20) begin @(posedge clk); #1; n++; end
        b_req_handle = h;
        b_req_sample = s;
        b_req_delay_inc = inc;
        b_req_valid = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        err = b_req_err;
        got = 1'b0;
        d = '0;
        for (int k = 0; k < 10 && !err && !got; k++) begin
            @(posedge clk); #1;
            if (b_resp_valid) begin got = 1'b1; d = b_resp_data; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        vec_cnt++;
        if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_ready: a=%0b b=%0b, want 1 1", a_req_ready, b_req_ready);
        end
        vec_cnt++;
        if ({a_alloc_ack, a_alloc_err, a_req_err, a_resp_valid} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL reset_pulses: ack,err,req_err,resp_valid=%b, want 0000",
                     {a_alloc_ack, a_alloc_err, a_req_err, a_resp_valid});
        end
        vec_cnt++;
        if (a_resp_data !== 16'd0 || a_alloc_handle !== 3'd0 || a_resp_handle !== 3'd0) begin
            err_cnt++;
            $display("FAIL reset_data: data=%0d ahandle=%0d rhandle=%0d, want 0 0 0",
                     a_resp_data, a_alloc_handle, a_resp_handle);
        end
    endtask

    task automatic test_integer_delay();
        logic ack, err, got, rerr;
        logic [2:0] h;
        logic [15:0] d, want;
        do_reset();
        a_alloc(12'd8, 20'h00200, ack, err, h);
        vec_cnt++;
        if ({ack, err, h} !== 5'b10000) begin
            err_cnt++;
            $display("FAIL t1_alloc: ack=%0b err=%0b handle=%0d, want 1 0 0", ack, err, h);
        end
        for (int n = 1; n <= 20; n++) begin
            a_req(3'd0, 16'(n), 16'h0000, got, rerr, d);
            want = (n <= 9) ? 16'd0 : 16'(n - 2);
            vec_cnt++;
            if (!got || rerr || d !== want || a_resp_handle !== 3'd0) begin
                err_cnt++;
                $display("FAIL t1_sample n=%0d: got=%0b err=%0b data=%0d handle=%0d, want data=%0d handle=0",
                         n, got, rerr, d, a_resp_handle, want);
            end
        end
    endtask

    task automatic test_frac_delay();
        logic ack, err, got, rerr;
        logic [2:0] h;
        logic [15:0] d, want;
        do_reset();
        a_alloc(12'd8, 20'h00280, ack, err, h);
        for (int n = 1; n <= 16; n++) begin
            a_req(3'd0, 16'(100 * n), 16'h0000, got, rerr, d);
            want = (n <= 9) ? 16'd0 : 16'(100 * n - 250);
            vec_cnt++;
            if (!got || rerr || d !== want) begin
                err_cnt++;
                $display("FAIL t2_frac n=%0d: got=%0b data=%0d, want %0d", n, got, $signed(d), $signed(want));
            end
        end
    endtask

    task automatic test_slew_clamp();
        logic ack, err, got, rerr;
        logic [2:0] h;
        logic [15:0] d, want, inc;
        do_reset();
        a_alloc(12'd8, 20'h00200, ack, err, h);
        for (int n = 1; n <= 20; n++) begin
            inc = (n <= 16) ? 16'h7FFF : 16'h8000;
            a_req(3'd0, 16'(100 * n), inc, got, rerr, d);
            want = (n <= 9) ? 16'd0 : (n <= 17) ? 16'(100 * (n - 7)) : 16'(100 * n);
            vec_cnt++;
            if (!got || rerr || d !== want) begin
                err_cnt++;
                $display("FAIL t3_slew n=%0d: got=%0b data=%0d, want %0d", n, got, $signed(d), $signed(want));
            end
        end
    endtask

    task automatic test_bad_handle();
        logic ack, err, got, rerr, seen, busy, extra;
        logic [2:0] h;
        logic [15:0] d;
        do_reset();
        a_alloc(12'd8, 20'h0, ack, err, h);
        a_req(3'd3, 16'h1111, 16'h0000, got, rerr, d);
        vec_cnt++;
        if (rerr !== 1'b1 || a_req_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL t4_req_err: req_err=%0b ready=%0b, want 1 1", rerr, a_req_ready);
        end
        seen = 1'b0; busy = 1'b0; extra = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (a_resp_valid) seen = 1'b1;
            if (!a_req_ready) busy = 1'b1;
            if (a_req_err) extra = 1'b1;
        end
        vec_cnt++;
        if (seen || busy || extra) begin
            err_cnt++;
            $display("FAIL t4_quiet: resp_seen=%0b not_ready=%0b err_repeat=%0b, want 0 0 0", seen, busy, extra);
        end
    endtask

    task automatic test_enable_pause();
        logic ack, err, got, rerr, seen;
        logic [2:0] h;
        logic [15:0] d;
        do_reset();
        a_alloc(12'd8, 20'h0, ack, err, h);
        for (int n = 1; n <= 9; n++) a_req(3'd0, 16'(n), 16'h0000, got, rerr, d);
        a_req_handle = 3'd0;
        a_req_sample = 16'h1234;
        a_req_delay_inc = 16'h0000;
        a_req_valid = 1'b1;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        @(posedge clk); #1;
        enable = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (a_resp_valid) seen = 1'b1;
        end
        enable = 1'b1;
        got = 1'b0;
        d = '0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk); #1;
            if (a_resp_valid) begin got = 1'b1; d = a_resp_data; end
        end
        vec_cnt++;
        if (seen) begin
            err_cnt++;
            $display("FAIL pause_quiet: resp_valid seen while disabled, want none");
        end
        vec_cnt++;
        if (!got || d !== 16'h1234) begin
            err_cnt++;
            $display("FAIL pause_resume: got=%0b data=%h, want 1 1234", got, d);
        end
    endtask

    task automatic test_alloc_limits();
        logic ack, err, got, rerr;
        logic [0:0] h;
        logic [15:0] d;
        logic [3:0] sizes [5];
        logic [2:0] want [5];
        sizes = '{4'd1, 4'd10, 4'd10, 4'd6, 4'd2};
        want  = '{3'b010, 3'b100, 3'b010, 3'b101, 3'b010};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            b_alloc(sizes[i], 12'h0, ack, err, h);
            vec_cnt++;
            if ({ack, err, (ack ? h : 1'b0)} !== want[i]) begin
                err_cnt++;
                $display("FAIL t5_alloc%0d size=%0d: ack=%0b err=%0b handle=%0d, want ack,err,handle=%b",
                         i, sizes[i], ack, err, h, want[i]);
            end
        end
        b_req(1'b1, 16'h0042, 16'h0000, got, rerr, d);
        vec_cnt++;
        if (!got || rerr || b_resp_handle !== 1'b1) begin
            err_cnt++;
            $display("FAIL t5_handle1: got=%0b err=%0b resp_handle=%0d, want 1 0 1", got, rerr, b_resp_handle);
        end
    endtask

    task automatic test_reset_midop_ramp();
        logic ack, err, got, rerr, seen;
        logic [0:0] h;
        logic [15:0] d, want;
        do_reset();
        b_alloc(4'd4, 12'h0, ack, err, h);
        b_req_handle = 1'b0;
        b_req_sample = 16'h0100;
        b_req_delay_inc = 16'h0000;
        b_req_valid = 1'b1;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (b_resp_valid) seen = 1'b1;
        end
        vec_cnt++;
        if (seen || b_req_ready !== 1'b1) begin
            err_cnt++;
            $display("FAIL t6_midop_reset: resp_seen=%0b ready=%0b, want 0 1", seen, b_req_ready);
        end
        b_req(1'b0, 16'h0100, 16'h0000, got, rerr, d);
        vec_cnt++;
        if (rerr !== 1'b1 || got) begin
            err_cnt++;
            $display("FAIL t6_post_reset_err: req_err=%0b resp=%0b, want 1 0", rerr, got);
        end
        b_alloc(4'd4, 12'h0, ack, err, h);
        vec_cnt++;
        if (ack !== 1'b1 || h !== 1'b0) begin
            err_cnt++;
            $display("FAIL t6_realloc: ack=%0b handle=%0d, want 1 0", ack, h);
        end
        for (int n = 1; n <= 9; n++) begin
            b_req(1'b0, 16'h4000, 16'h0000, got, rerr, d);
            want = (n <= 5) ? 16'd0 : 16'(64 * (n - 5));
            vec_cnt++;
            if (!got || rerr || d !== want) begin
                err_cnt++;
                $display("FAIL t6_ramp n=%0d: got=%0b data=%0d, want %0d", n, got, d, want);
            end
        end
    endtask

    initial begin
        a_alloc_size = '0; a_alloc_delay = '0; a_req_handle = '0; a_req_sample = '0; a_req_delay_inc = '0;
        b_alloc_size = '0; b_alloc_delay = '0; b_req_handle = '0; b_req_sample = '0; b_req_delay_inc = '0;
        test_reset();
        test_integer_delay();
        test_frac_delay();
        test_slew_clamp();
        test_bad_handle();
        test_enable_pause();
        test_alloc_limits();
        test_reset_midop_ramp();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vec_cnt, err_cnt);
        $fatal(1);
    end
endmodule
